// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM encodings, digit width
// and a helper that sizes the BCD result for a given binary width.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } bcd_state_t;

    localparam int DIGIT_W = 4;

    // Decimal digits needed to represent 2^nbits-1 (nbits up to 63).
    function automatic int bcd_digits_needed(input int nbits);
        longint unsigned v;
        int d;
        v = '1;
        v = v >> (64 - nbits);
        d = 1;
        for (int i = 0; i < 20; i++) begin
            if (v >= 64'd10) begin
                v = v / 64'd10;
                d = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decade.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock.
// State | meaning:  IDLE | waiting for start;  CONV | shifting bits;  DONE | result pulse cycle.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int num_bits   = 16,
    parameter int num_digits = 5
) (
    input  logic                          in_clk,
    input  logic                          in_rst,
    input  logic                          in_start,
    input  logic [num_bits-1:0]           in_bin,
    output logic [num_digits*DIGIT_W-1:0] out_bcd,
    output logic                          out_busy,
    output logic                          out_done
);

    localparam int BCD_W = num_digits * DIGIT_W;
    localparam int CNT_W = $clog2(num_bits);

    if (num_bits < 2 || num_bits > 63) begin : g_bad_bits
        $error("bin2bcd_seq: num_bits must be in 2..63");
    end
    if (num_digits < bcd_digits_needed(num_bits)) begin : g_bad_digits
        $error("bin2bcd_seq: num_digits too small for num_bits");
    end

    bcd_state_t          state;
    logic [BCD_W-1:0]    scratch;
    logic [BCD_W-1:0]    adj;
    logic [BCD_W-1:0]    shifted;
    logic [num_bits-1:0] bin_lat;
    logic [CNT_W-1:0]    cnt;
    logic                unused_top;

    for (genvar i = 0; i < num_digits; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (scratch[i*DIGIT_W +: DIGIT_W]),
            .adjusted (adj[i*DIGIT_W +: DIGIT_W])
        );
    end

    // The top bit falls off the shift; it is always zero because digits never overflow.
    assign shifted    = {adj[BCD_W-2:0], bin_lat[num_bits-1]};
    assign unused_top = adj[BCD_W-1];

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state    <= ST_IDLE;
            scratch  <= '0;
            bin_lat  <= '0;
            cnt      <= '0;
            out_bcd  <= '0;
            out_busy <= 1'b0;
            out_done <= 1'b0;
        end else begin
            out_done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (in_start) begin
                        bin_lat  <= in_bin;
                        scratch  <= '0;
                        cnt      <= CNT_W'(num_bits - 1);
                        out_busy <= 1'b1;
                        state    <= ST_CONV;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_CONV: begin
                    scratch <= shifted;
                    bin_lat <= bin_lat << 1;
                    if (cnt == '0) begin
                        out_bcd  <= shifted;
                        out_done <= 1'b1;
                        out_busy <= 1'b0;
                        state    <= ST_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    out_busy <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq at default (16/5) and reduced (8/3) sizes.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start16 = 1'b0;
    logic [15:0] bin16 = '0;
    logic [19:0] bcd16;
    logic        busy16, done16;
    logic        start8 = 1'b0;
    logic [7:0]  bin8 = '0;
    logic [11:0] bcd8;
    logic        busy8, done8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.num_bits(16), .num_digits(5)) u_dut16 (
        .in_clk(clk), .in_rst(rst), .in_start(start16), .in_bin(bin16),
        .out_bcd(bcd16), .out_busy(busy16), .out_done(done16)
    );

    bin2bcd_seq #(.num_bits(8), .num_digits(3)) u_dut8 (
        .in_clk(clk), .in_rst(rst), .in_start(start8), .in_bin(bin8),
        .out_bcd(bcd8), .out_busy(busy8), .out_done(done8)
    );

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd;
    } vec_t;

    // Reference: decimal digits of v by plain division, packed 4 bits per digit.
    function automatic logic [31:0] ref_bcd(input int unsigned v, input int nd);
        logic [31:0] r;
        int unsigned p;
        r = '0;
        p = 1;
        for (int i = 0; i < nd; i++) begin
            r[i*4 +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Pulse start for one cycle and measure latency, busy length and output stability.
    task automatic conv16(input logic [15:0] v, input logic [19:0] exp, input string name);
        int n, busy_n;
        logic [19:0] prev;
        logic glitch;
        prev = bcd16;
        glitch = 1'b0;
        @(negedge clk);
        bin16 = v;
        start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        n = 0;
        busy_n = 0;
        while (!done16 && n < 40) begin
            if (busy16) busy_n++;
            if (bcd16 !== prev) glitch = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_latency"}, 32'(n), 32'd16);
        chk({name, "_busy_len"}, 32'(busy_n), 32'd16);
        chk({name, "_bcd"}, 32'(bcd16), 32'(exp));
        chk({name, "_no_partial"}, 32'(glitch), 32'd0);
        @(posedge clk); #1;
        chk({name, "_done_pulse"}, 32'(done16), 32'd0);
    endtask

    task automatic conv8(input logic [7:0] v, input logic [11:0] exp, input bit full);
        int n;
        @(negedge clk);
        bin8 = v;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        if (full) chk("b8_latency", 32'(n), 32'd8);
        chk("b8_bcd", 32'(bcd8), 32'(exp));
    endtask

    vec_t vecs[6];

    initial begin
        int n, dones, gap;
        int unsigned r;

        vecs[0] = '{16'd0,     20'h00000};
        vecs[1] = '{16'd65535, 20'h65535};
        vecs[2] = '{16'd12345, 20'h12345};
        vecs[3] = '{16'd9,     20'h00009};
        vecs[4] = '{16'd1000,  20'h01000};
        vecs[5] = '{16'd99,    20'h00099};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_bcd", 32'(bcd16), 32'd0);
        chk("rst_busy", 32'(busy16), 32'd0);
        chk("rst_done", 32'(done16), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) conv16(vecs[i].bin, vecs[i].bcd, $sformatf("vec%0d", i));

        // Start pulse and input change mid-conversion must be ignored.
        @(negedge clk);
        bin16 = 16'd9;
        start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        dones = 0;
        n = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) begin
                start16 = 1'b1;
                bin16 = 16'd777;
            end
            if (c == 6) start16 = 1'b0;
            @(posedge clk); #1;
            if (done16) begin
                dones++;
                if (n == 0) n = c;
            end
        end
        chk("ign_done_count", 32'(dones), 32'd1);
        chk("ign_latency", 32'(n), 32'd16);
        chk("ign_bcd", 32'(bcd16), 32'h00009);

        // Back-to-back with start held high.
        @(negedge clk);
        bin16 = 16'd100;
        start16 = 1'b1;
        @(posedge clk); #1;
        bin16 = 16'd200;
        n = 0;
        while (!done16 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_first_latency", 32'(n), 32'd16);
        chk("b2b_first_bcd", 32'(bcd16), 32'h00100);
        gap = 0;
        @(posedge clk); #1;
        gap++;
        start16 = 1'b0;
        chk("b2b_busy_again", 32'(busy16), 32'd1);
        while (!done16 && gap < 40) begin
            @(posedge clk); #1;
            gap++;
        end
        chk("b2b_gap", 32'(gap), 32'd17);
        chk("b2b_second_bcd", 32'(bcd16), 32'h00200);

        // Reset 8 cycles into a conversion.
        @(negedge clk);
        bin16 = 16'd4321;
        start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("rstmid_bcd", 32'(bcd16), 32'd0);
        chk("rstmid_busy", 32'(busy16), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (done16 || bcd16 !== 20'h0) dones++;
        end
        chk("rstmid_no_done", 32'(dones), 32'd0);
        conv16(16'd4321, 20'h04321, "after_rst");

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 65535);
            conv16(16'(r), 20'(ref_bcd(r, 5)), "rand16");
        end

        conv8(8'd255, 12'h255, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            r = $urandom_range(0, 255);
            conv8(8'(r), 12'(ref_bcd(r, 3)), (i < 20));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter num_bits, default 16: width of the binary input, matching the upstream counter width.
REQ-002 Parameter num_digits, default 5: number of 4-bit BCD output digits.
REQ-003 in_clk  input  1: clock; all state changes on the rising edge.
REQ-004 in_rst  input  1: reset, asynchronous, active-high.
REQ-005 in_start  input  1: conversion request, sampled on the rising edge.
REQ-006 in_bin  input  num_bits: unsigned binary value to convert, typically the counter output.
REQ-007 out_bcd  output  num_digits*4: packed BCD result; digit 0 (ones) occupies bits [3:0].
REQ-008 out_busy  output  1: high while a conversion is in progress.
REQ-009 out_done  output  1: single-cycle pulse marking a new valid out_bcd.

Function
REQ-010 The block SHALL implement shift-add-3 (double dabble) conversion using an FSM with states IDLE, CONV and DONE.
REQ-011 In IDLE or DONE, in_start=1 at an edge SHALL latch in_bin, clear the BCD scratch register, load the bit counter with num_bits-1 and enter CONV; that edge is the accept edge.
REQ-012 Each CONV edge SHALL first add 3 to every scratch digit >= 5, then shift the scratch register left by one, inserting the latched input MSB; the latched input SHALL then shift left.
REQ-013 CONV SHALL last exactly num_bits edges after the accept edge; on the last of these, the final shifted scratch SHALL be registered into out_bcd and the FSM SHALL enter DONE.
REQ-014 Latency: out_done SHALL be high for exactly one cycle, starting num_bits edges after the accept edge (16 cycles at defaults).
REQ-015 out_busy SHALL be high exactly while the FSM is in CONV, and low in IDLE and DONE.
REQ-016 DONE SHALL last one cycle, then return to IDLE, unless in_start=1 in that cycle; a start then SHALL be accepted directly (back-to-back, no idle gap).
REQ-017 in_start while in CONV SHALL be ignored; it SHALL NOT queue and SHALL NOT affect the current conversion.
REQ-018 Changes on in_bin after the accept edge SHALL NOT affect the result.
REQ-019 out_bcd SHALL hold the last completed result until the next completion; it SHALL never show partial scratch values.
REQ-020 Widths: num_digits*4 >= bits needed for 2^num_bits-1 in BCD; an illegal combination SHALL be rejected at elaboration time (e.g. an error for 16/4).
REQ-021 Maximum input (all ones) SHALL convert without digit overflow; every out_bcd digit SHALL always be in 0..9.

Reset
REQ-022 While in_rst is high: FSM = IDLE, out_bcd = 0, out_busy = 0, out_done = 0, scratch, latched input and bit counter = 0.
REQ-023 Reset during CONV SHALL abort the conversion immediately; no out_done pulse and no out_bcd update SHALL follow.
REQ-024 After reset deassertion, the first in_start edge SHALL be accepted normally.

Structure
REQ-025 The FSM state encodings (IDLE, CONV, DONE) and the BCD digit width constant (4) SHALL live in shared package bcd_pkg.
REQ-026 Per-digit correction (if digit >= 5, add 3) SHALL be one combinational sub-module, bcd_digit_adj, instantiated num_digits times via generate.
REQ-027 The bit counter SHALL be sized as clog2(num_bits) bits.

Verification
REQ-028 Zero input: reset, then in_bin=0 with 1-cycle start -> out_done at edge +16, out_bcd=0x00000, out_busy high for 16 cycles.
REQ-029 Maximum input: in_bin=65535 -> out_bcd=0x65535; in_bin=12345 -> out_bcd=0x12345, each exactly 16 cycles after accept.
REQ-030 Start during conversion: start 9 with another start pulse 5 cycles later -> single out_done, result 0x00009; in_bin changed to 777 mid-conversion has no effect.
REQ-031 Back-to-back: start held high continuously with in_bin 100 then 200 -> out_done pulses 17 cycles apart, out_bcd 0x00100 then 0x00200.
REQ-032 Reset mid-conversion: assert in_rst 8 cycles after accepting 4321 -> outputs 0 immediately, no out_done; a new start of 4321 yields 0x04321.
REQ-033 Alternate parameters: num_bits=8, num_digits=3, in_bin=255 -> out_bcd=0x255 at edge +8; randomized comparison against a reference model over 1000 values.
